// File: rtl/pmt_order_checker_pkg.sv
// Shared constants and types for the merge-tree order checker.
// Record geometry defaults and status encodings live here.
package pmt_order_checker_pkg;

  localparam int P_LOG_D = 3;
  localparam int RCDW_D  = 32;
  localparam int CNTW_D  = 32;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ORDER   = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/pmt_lane_cmp.sv
// Combinational order check of one merged word against itself
// and against the last record of the previous word.
module pmt_lane_cmp
  import pmt_order_checker_pkg::*;
#(
  parameter int P_LOG = P_LOG_D,
  parameter int RCDW  = RCDW_D
) (
  input  logic [RCDW-1:0]              prev_last,
  input  logic                         have_prev,
  input  logic [RCDW*(1<<P_LOG)-1:0]   lanes,
  output logic                         viol,
  output logic [P_LOG-1:0]             viol_idx
);

  localparam int P = 1 << P_LOG;

  logic [P-1:0] bad;

  // bad[j] flags the larger-indexed record of a failing pair
  always_comb begin
    bad    = '0;
    bad[0] = have_prev && (prev_last > lanes[0 +: RCDW]);
    for (int i = 1; i < P; i++) begin
      bad[i] = lanes[(i-1)*RCDW +: RCDW] > lanes[i*RCDW +: RCDW];
    end
  end

  always_comb begin
    viol_idx = '0;
    for (int i = P - 1; i >= 0; i--) begin
      if (bad[i]) viol_idx = P_LOG'(i);
    end
  end

  assign viol = |bad;

endmodule

// File: rtl/pmt_order_checker.sv
// Sink for the merge tree: checks non-decreasing order and counts
// records, ending in PASS or FAIL with the first bad record index.
module pmt_order_checker
  import pmt_order_checker_pkg::*;
#(
  parameter int P_LOG = P_LOG_D,
  parameter int RCDW  = RCDW_D,
  parameter int CNTW  = CNTW_D
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [RCDW*(1<<P_LOG)-1:0]  DIN,
  input  logic                        DINEN,
  input  logic [CNTW-1:0]             EXPECT_CNT,
  output logic                        DONE,
  output logic                        ERR,
  output logic [1:0]                  ERR_CODE,
  output logic [CNTW-1:0]             ERR_IDX,
  output logic [CNTW-1:0]             REC_CNT
);

  localparam int P = 1 << P_LOG;

  logic [RCDW*P-1:0] din_q;
  logic              vld_q;

  state_t            st, st_nx;
  logic [CNTW-1:0]   cnt, cnt_nx;
  logic [CNTW-1:0]   idx, idx_nx;
  logic [1:0]        code, code_nx;
  logic [RCDW-1:0]   last, last_nx;
  logic              hp, hp_nx;

  logic              viol;
  logic [P_LOG-1:0]  vidx;
  logic [CNTW:0]     cnt_sum;
  logic [CNTW-1:0]   cnt_sat;

  pmt_lane_cmp #(
    .P_LOG (P_LOG),
    .RCDW  (RCDW)
  ) u_cmp (
    .prev_last (last),
    .have_prev (hp),
    .lanes     (din_q),
    .viol      (viol),
    .viol_idx  (vidx)
  );

  // carry out of the add means the counter pins at all-ones
  assign cnt_sum = {1'b0, cnt} + (CNTW+1)'(P);
  assign cnt_sat = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      din_q <= '0;
      vld_q <= 1'b0;
      st    <= ST_RUN;
      cnt   <= '0;
      idx   <= '0;
      code  <= ERR_NONE;
      last  <= '0;
      hp    <= 1'b0;
    end else begin
      din_q <= DIN;
      vld_q <= DINEN;
      st    <= st_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      code  <= code_nx;
      last  <= last_nx;
      hp    <= hp_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    idx_nx  = idx;
    code_nx = code;
    last_nx = last;
    hp_nx   = hp;
    unique case (st)
      ST_RUN: begin
        if (vld_q) begin
          if (viol) begin
            st_nx   = ST_FAIL;
            code_nx = ERR_ORDER;
            idx_nx  = cnt + CNTW'(vidx);
          end else begin
            cnt_nx  = cnt_sat;
            last_nx = din_q[(P-1)*RCDW +: RCDW];
            hp_nx   = 1'b1;
            if (cnt_sat == EXPECT_CNT) st_nx = ST_PASS;
          end
        end else if (EXPECT_CNT == '0) begin
          st_nx = ST_PASS;
        end
      end
      ST_PASS: begin
        if (vld_q) begin
          st_nx   = ST_FAIL;
          code_nx = ERR_OVERRUN;
          idx_nx  = cnt;
        end
      end
      ST_FAIL: begin
        st_nx = ST_FAIL;
      end
      default: begin
        st_nx = ST_RUN;
      end
    endcase
  end

  assign DONE     = (st != ST_RUN);
  assign ERR      = (st == ST_FAIL);
  assign ERR_CODE = code;
  assign ERR_IDX  = idx;
  assign REC_CNT  = cnt;

endmodule

// File: tb/tb_pmt_order_checker.sv
// Scoreboard bench for pmt_order_checker: a record-by-record model
// queues the expected status for each driven cycle, popped two cycles later.
module tb_pmt_order_checker;
  import pmt_order_checker_pkg::*;

  localparam int P  = 8;
  localparam int RW = 32;
  localparam int CW = 32;

  logic            CLK = 1'b0;
  logic            RST;
  logic [RW*P-1:0] DIN;
  logic            DINEN;
  logic [CW-1:0]   EXPECT_CNT;
  logic            DONE;
  logic            ERR;
  logic [1:0]      ERR_CODE;
  logic [CW-1:0]   ERR_IDX;
  logic [CW-1:0]   REC_CNT;

  always #5 CLK = ~CLK;

  pmt_order_checker #(
    .P_LOG (3),
    .RCDW  (RW),
    .CNTW  (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIN        (DIN),
    .DINEN      (DINEN),
    .EXPECT_CNT (EXPECT_CNT),
    .DONE       (DONE),
    .ERR        (ERR),
    .ERR_CODE   (ERR_CODE),
    .ERR_IDX    (ERR_IDX),
    .REC_CNT    (REC_CNT)
  );

  typedef struct packed {
    logic          done;
    logic          err;
    logic [1:0]    code;
    logic [CW-1:0] idx;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // model: 0 run, 1 pass, 2 fail
  int            m_st;
  logic [CW-1:0] m_cnt, m_idx, m_exp;
  logic [1:0]    m_code;
  logic [RW-1:0] m_last;
  logic          m_hp;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.done = (m_st != 0);
    e.err  = (m_st == 2);
    e.code = m_code;
    e.idx  = m_idx;
    e.cnt  = m_cnt;
    return e;
  endfunction

  task automatic m_reset(input logic [CW-1:0] exp);
    m_st   = (exp == '0) ? 1 : 0;
    m_cnt  = '0;
    m_idx  = '0;
    m_code = 2'd0;
    m_last = '0;
    m_hp   = 1'b0;
    m_exp  = exp;
  endtask

  // walk the records in stream order, stopping at the first drop
  task automatic m_word(input logic [RW*P-1:0] w);
    logic [RW-1:0] rec;
    if (m_st == 2) return;
    if (m_st == 1) begin
      m_st = 2; m_code = 2'd2; m_idx = m_cnt;
      return;
    end
    for (int i = 0; i < P; i++) begin
      rec = w[i*RW +: RW];
      if (m_hp && m_last > rec) begin
        m_st = 2; m_code = 2'd1; m_idx = m_cnt + CW'(i);
        return;
      end
      m_last = rec;
      m_hp   = 1'b1;
    end
    m_cnt = (m_cnt > ('1 - CW'(P))) ? '1 : m_cnt + CW'(P);
    if (m_cnt == m_exp) m_st = 1;
  endtask

  task automatic pop_chk();
    exp_t e;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("done", 64'(DONE), 64'(e.done));
      chk("err", 64'(ERR), 64'(e.err));
      chk("code", 64'(ERR_CODE), 64'(e.code));
      chk("idx", 64'(ERR_IDX), 64'(e.idx));
      chk("cnt", 64'(REC_CNT), 64'(e.cnt));
    end
  endtask

  task automatic cyc(input logic [RW*P-1:0] w, input logic v);
    @(negedge CLK);
    pop_chk();
    RST   = 1'b1;
    DIN   = w;
    DINEN = v;
    if (v) m_word(w);
    q.push_back(snap());
  endtask

  // reset lands one edge after drive, so it also voids the prior entry
  task automatic rst_cyc(input logic [CW-1:0] exp,
                         input logic [RW*P-1:0] w, input logic v);
    exp_t z;
    @(negedge CLK);
    pop_chk();
    RST        = 1'b0;
    EXPECT_CNT = exp;
    DIN        = w;
    DINEN      = v;
    z = '0;
    if (q.size() > 0) q[$] = z;
    m_reset(exp);
    q.push_back(snap());
  endtask

  function automatic logic [RW*P-1:0] ramp(input int unsigned b);
    logic [RW*P-1:0] w;
    for (int i = 0; i < P; i++) w[i*RW +: RW] = b + i;
    return w;
  endfunction

  function automatic logic [RW*P-1:0] w8(
    input int unsigned a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  initial begin
    logic [RW*P-1:0] w;
    logic [RW-1:0]   v;
    int              k;
    RST = 1'b0; DIN = '0; DINEN = 1'b0; EXPECT_CNT = 16;
    m_reset(16);

    // two back-to-back words reach the count
    rst_cyc(16, '0, 1'b0);
    rst_cyc(16, '0, 1'b0);
    cyc(ramp(0), 1'b1);
    cyc(ramp(8), 1'b1);
    cyc('0, 1'b0);
    cyc('0, 1'b0);

    // equal keys across the boundary
    rst_cyc(16, '0, 1'b0);
    cyc(ramp(0), 1'b1);
    cyc(w8(7, 7, 9, 10, 11, 12, 13, 14), 1'b1);
    cyc('0, 1'b0);

    // cross-word drop, then ignored words in FAIL
    rst_cyc(16, '0, 1'b0);
    cyc(ramp(0), 1'b1);
    cyc(ramp(5), 1'b1);
    cyc(ramp(100), 1'b1);
    cyc('0, 1'b0);

    // two in-word drops, lowest lane reported
    rst_cyc(16, '0, 1'b0);
    cyc(w8(0, 1, 2, 1, 4, 5, 3, 7), 1'b1);
    cyc('0, 1'b0);
    cyc('0, 1'b0);

    // overrun after PASS
    rst_cyc(8, '0, 1'b0);
    cyc(ramp(0), 1'b1);
    cyc(ramp(8), 1'b1);
    cyc('0, 1'b0);
    cyc('0, 1'b0);

    // mid-run reset with a word in flight, then empty run
    rst_cyc(16, '0, 1'b0);
    cyc(ramp(0), 1'b1);
    rst_cyc(0, ramp(50), 1'b1);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);

    // random sorted stream with idle gaps
    rst_cyc(64, '0, 1'b0);
    v = $urandom_range(0, 1000);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < P; i++) begin
        v = v + $urandom_range(0, 3);
        w[i*RW +: RW] = v;
      end
      cyc(w, 1'b1);
      if ($urandom_range(0, 1) == 1) cyc('0, 1'b0);
    end
    cyc('0, 1'b0);

    // random in-word drop at a random lane
    rst_cyc(64, '0, 1'b0);
    cyc(ramp(10), 1'b1);
    w = ramp(20);
    k = $urandom_range(1, P - 1);
    w[k*RW +: RW] = 20 + k - 2;
    cyc(w, 1'b1);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
